// File: rtl/fifo_wr_arbiter_if.sv
// Write-side bundle between N_REQ producers, the arbiter and the sync FIFO write port.
// master: producers + FIFO flag source; slave: the arbiter.
interface fifo_wr_arbiter_if #(
  parameter int N_REQ      = 4,
  parameter int DATA_WIDTH = 32
);
  logic [N_REQ-1:0]            i_req_valid;
  logic [N_REQ*DATA_WIDTH-1:0] i_req_data;
  logic [N_REQ-1:0]            i_req_last;
  logic [N_REQ-1:0]            o_req_ready;
  logic                        i_fifo_full;
  logic                        o_fifo_wr_en;
  logic [DATA_WIDTH-1:0]       o_fifo_data;
  logic [N_REQ-1:0]            o_grant;
  logic                        o_busy;

  modport master (
    output i_req_valid, i_req_data, i_req_last, i_fifo_full,
    input  o_req_ready, o_fifo_wr_en, o_fifo_data, o_grant, o_busy
  );

  modport slave (
    input  i_req_valid, i_req_data, i_req_last, i_fifo_full,
    output o_req_ready, o_fifo_wr_en, o_fifo_data, o_grant, o_busy
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin packet arbiter sharing one sync FIFO write port among N_REQ producers.
// A grant is held for a whole packet, or until MAX_BURST beats force a release.
module fifo_wr_arbiter #(
  parameter int N_REQ      = 4,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_BURST  = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  fifo_wr_arbiter_if.slave  bus
);
  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CNT_W = $clog2(MAX_BURST + 1);

  typedef enum logic {IDLE, BURST} state_t;

  state_t                 state_reg;
  logic [N_REQ-1:0]       grant_reg;
  logic [PTR_W-1:0]       grant_idx_reg;
  logic [PTR_W-1:0]       rr_ptr_reg;
  logic [CNT_W-1:0]       beat_cnt_reg;
  logic                   busy_reg;

  logic [DATA_WIDTH-1:0]  req_data_arr [N_REQ];
  logic                   pick_found;
  logic [PTR_W-1:0]       pick_idx;
  logic                   beat_ok;
  logic                   burst_end;
  logic [PTR_W-1:0]       rr_ptr_next;

  // grant_reg is all-zero outside BURST, so ready needs no state qualifier
  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_req
    assign req_data_arr[gi]     = bus.i_req_data[gi*DATA_WIDTH +: DATA_WIDTH];
    assign bus.o_req_ready[gi]  = grant_reg[gi] & ~bus.i_fifo_full;
  end

  assign beat_ok   = (state_reg == BURST) & bus.i_req_valid[grant_idx_reg] & ~bus.i_fifo_full;
  assign burst_end = beat_ok & (bus.i_req_last[grant_idx_reg] |
                                (beat_cnt_reg == CNT_W'(MAX_BURST - 1)));

  assign bus.o_fifo_wr_en = beat_ok;
  assign bus.o_fifo_data  = beat_ok ? req_data_arr[grant_idx_reg] : '0;
  assign bus.o_grant      = grant_reg;
  assign bus.o_busy       = busy_reg;

  assign rr_ptr_next = (grant_idx_reg == PTR_W'(N_REQ - 1)) ? '0 : grant_idx_reg + 1'b1;

  // First valid requester at or above rr_ptr, wrapping past N_REQ-1
  always_comb begin
    logic [PTR_W:0] cand;
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int i = 0; i < N_REQ; i++) begin
      cand = {1'b0, rr_ptr_reg} + (PTR_W+1)'(i);
      if (cand >= (PTR_W+1)'(N_REQ)) begin
        cand = cand - (PTR_W+1)'(N_REQ);
      end
      if (!pick_found && bus.i_req_valid[cand[PTR_W-1:0]]) begin
        pick_found = 1'b1;
        pick_idx   = cand[PTR_W-1:0];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_reg     <= IDLE;
      grant_reg     <= '0;
      grant_idx_reg <= '0;
      rr_ptr_reg    <= '0;
      beat_cnt_reg  <= '0;
      busy_reg      <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (pick_found) begin
            state_reg     <= BURST;
            busy_reg      <= 1'b1;
            grant_reg     <= {{(N_REQ-1){1'b0}}, 1'b1} << pick_idx;
            grant_idx_reg <= pick_idx;
            beat_cnt_reg  <= '0;
          end
        end
        BURST: begin
          if (beat_ok) begin
            beat_cnt_reg <= beat_cnt_reg + 1'b1;
          end
          if (burst_end) begin
            state_reg  <= IDLE;
            busy_reg   <= 1'b0;
            grant_reg  <= '0;
            rr_ptr_reg <= rr_ptr_next;
          end
        end
        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
          grant_reg <= '0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter (N_REQ=4, MAX_BURST=4): each step drives
// all inputs for one cycle and checks every output against hand-computed values.
module tb_fifo_wr_arbiter;
  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;

  fifo_wr_arbiter_if #(.N_REQ(4), .DATA_WIDTH(32)) bus ();

  fifo_wr_arbiter #(.N_REQ(4), .DATA_WIDTH(32), .MAX_BURST(4)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    vectors++;
    assert (obs === exp_v) else begin
      miscompares++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
      $error("%s check did not hold", tag);
    end
  endtask

  // Drive one cycle of inputs, check outputs mid-cycle, then advance past the edge
  task automatic step(input string tag, input logic [3:0] v, input logic [3:0] l,
                      input logic [7:0] d0, input logic [7:0] d1,
                      input logic [7:0] d2, input logic [7:0] d3, input logic full,
                      input logic [3:0] eg, input logic eb, input logic [3:0] er,
                      input logic ew, input logic [31:0] ed);
    bus.i_req_valid = v;
    bus.i_req_last  = l;
    bus.i_req_data  = {24'h0, d3, 24'h0, d2, 24'h0, d1, 24'h0, d0};
    bus.i_fifo_full = full;
    #1;
    chk({tag, ".grant"}, 32'(bus.o_grant), 32'(eg));
    chk({tag, ".busy"},  32'(bus.o_busy), 32'(eb));
    chk({tag, ".ready"}, 32'(bus.o_req_ready), 32'(er));
    chk({tag, ".wr_en"}, 32'(bus.o_fifo_wr_en), 32'(ew));
    chk({tag, ".data"},  bus.o_fifo_data, ed);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int cnt [4];
    vectors     = 0;
    miscompares = 0;
    rst = 1'b1;
    bus.i_req_valid = '0;
    bus.i_req_last  = '0;
    bus.i_req_data  = '0;
    bus.i_fifo_full = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Reset state
    step("reset", 4'h0, 4'h0, 8'h0, 8'h0, 8'h0, 8'h0, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 32'h0);
    chk("reset.rr_ptr", 32'(dut.rr_ptr_reg), 32'd0);
    chk("reset.beat_cnt", 32'(dut.beat_cnt_reg), 32'd0);
    rst = 1'b0;

    // Single requester 2, three beats
    step("t1.arb", 4'h4, 4'h0, 8'h0, 8'h0, 8'hA0, 8'h0, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 32'h0);
    step("t1.b0",  4'h4, 4'h0, 8'h0, 8'h0, 8'hA0, 8'h0, 1'b0, 4'h4, 1'b1, 4'h4, 1'b1, 32'hA0);
    step("t1.b1",  4'h4, 4'h0, 8'h0, 8'h0, 8'hA1, 8'h0, 1'b0, 4'h4, 1'b1, 4'h4, 1'b1, 32'hA1);
    step("t1.b2",  4'h4, 4'h4, 8'h0, 8'h0, 8'hA2, 8'h0, 1'b0, 4'h4, 1'b1, 4'h4, 1'b1, 32'hA2);
    chk("t1.rr_ptr", 32'(dut.rr_ptr_reg), 32'd3);
    step("t1.idle", 4'h0, 4'h0, 8'h0, 8'h0, 8'h0, 8'h0, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 32'h0);

    // Re-reset so the round-robin sweep starts at requester 0
    rst = 1'b1;
    step("t2.rst", 4'h0, 4'h0, 8'h0, 8'h0, 8'h0, 8'h0, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 32'h0);
    rst = 1'b0;

    // All four valid, 2-beat packets: order 0,1,2,3,0 at 3 cycles per packet
    for (int k = 0; k < 4; k++) cnt[k] = 0;
    for (int c = 0; c < 15; c++) begin
      int pos;
      int g;
      logic [3:0] l;
      logic [3:0] eg;
      pos = c % 3;
      g   = (c / 3) % 4;
      for (int k = 0; k < 4; k++) l[k] = (cnt[k] % 2) == 1;
      eg = (pos == 0) ? 4'h0 : (4'h1 << g);
      step("t2.rr", 4'hF, l, 8'(cnt[0]), 8'(16 + cnt[1]), 8'(32 + cnt[2]), 8'(48 + cnt[3]),
           1'b0, eg, pos != 0, eg, pos != 0,
           (pos == 0) ? 32'h0 : 32'(g * 16 + 2 * (c / 12) + (pos - 1)));
      if (pos != 0) cnt[g]++;
    end
    chk("t2.rr_ptr", 32'(dut.rr_ptr_reg), 32'd1);

    // Full stall on requester 1 mid-packet
    step("t3.arb", 4'h2, 4'h0, 8'h0, 8'h31, 8'h0, 8'h0, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 32'h0);
    step("t3.b0",  4'h2, 4'h0, 8'h0, 8'h31, 8'h0, 8'h0, 1'b0, 4'h2, 1'b1, 4'h2, 1'b1, 32'h31);
    for (int s = 0; s < 4; s++) begin
      step("t3.full", 4'h2, 4'h0, 8'h0, 8'h32, 8'h0, 8'h0, 1'b1, 4'h2, 1'b1, 4'h0, 1'b0, 32'h0);
      chk("t3.beat_cnt", 32'(dut.beat_cnt_reg), 32'd1);
    end
    step("t3.b1",  4'h2, 4'h0, 8'h0, 8'h32, 8'h0, 8'h0, 1'b0, 4'h2, 1'b1, 4'h2, 1'b1, 32'h32);
    step("t3.b2",  4'h2, 4'h2, 8'h0, 8'h33, 8'h0, 8'h0, 1'b0, 4'h2, 1'b1, 4'h2, 1'b1, 32'h33);
    step("t3.idle", 4'h0, 4'h0, 8'h0, 8'h0, 8'h0, 8'h0, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 32'h0);

    // Forced release after 4 beats of req 0; req 1 served, then req 0 resumes
    step("t4.arb0", 4'h3, 4'h0, 8'h40, 8'h50, 8'h0, 8'h0, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 32'h0);
    step("t4.b0",   4'h3, 4'h0, 8'h40, 8'h50, 8'h0, 8'h0, 1'b0, 4'h1, 1'b1, 4'h1, 1'b1, 32'h40);
    step("t4.b1",   4'h3, 4'h0, 8'h41, 8'h50, 8'h0, 8'h0, 1'b0, 4'h1, 1'b1, 4'h1, 1'b1, 32'h41);
    step("t4.b2",   4'h3, 4'h0, 8'h42, 8'h50, 8'h0, 8'h0, 1'b0, 4'h1, 1'b1, 4'h1, 1'b1, 32'h42);
    step("t4.b3",   4'h3, 4'h0, 8'h43, 8'h50, 8'h0, 8'h0, 1'b0, 4'h1, 1'b1, 4'h1, 1'b1, 32'h43);
    step("t4.arb1", 4'h3, 4'h0, 8'h44, 8'h50, 8'h0, 8'h0, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 32'h0);
    step("t4.r1b0", 4'h3, 4'h0, 8'h44, 8'h50, 8'h0, 8'h0, 1'b0, 4'h2, 1'b1, 4'h2, 1'b1, 32'h50);
    step("t4.r1b1", 4'h3, 4'h2, 8'h44, 8'h51, 8'h0, 8'h0, 1'b0, 4'h2, 1'b1, 4'h2, 1'b1, 32'h51);
    step("t4.arb2", 4'h1, 4'h0, 8'h44, 8'h0, 8'h0, 8'h0, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 32'h0);
    step("t4.b4",   4'h1, 4'h0, 8'h44, 8'h0, 8'h0, 8'h0, 1'b0, 4'h1, 1'b1, 4'h1, 1'b1, 32'h44);
    step("t4.b5",   4'h1, 4'h1, 8'h45, 8'h0, 8'h0, 8'h0, 1'b0, 4'h1, 1'b1, 4'h1, 1'b1, 32'h45);
    step("t4.idle", 4'h0, 4'h0, 8'h0, 8'h0, 8'h0, 8'h0, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 32'h0);

    // Valid gap on granted req 3 while req 0 waits (rr_ptr = 1 finds 3 first)
    step("t5.arb",  4'h9, 4'h0, 8'h70, 8'h0, 8'h0, 8'h60, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 32'h0);
    step("t5.b0",   4'h9, 4'h0, 8'h70, 8'h0, 8'h0, 8'h60, 1'b0, 4'h8, 1'b1, 4'h8, 1'b1, 32'h60);
    for (int s = 0; s < 3; s++) begin
      step("t5.gap", 4'h1, 4'h0, 8'h70, 8'h0, 8'h0, 8'h0, 1'b0, 4'h8, 1'b1, 4'h8, 1'b0, 32'h0);
    end
    step("t5.b1",   4'h9, 4'h0, 8'h70, 8'h0, 8'h0, 8'h61, 1'b0, 4'h8, 1'b1, 4'h8, 1'b1, 32'h61);
    step("t5.b2",   4'h9, 4'h8, 8'h70, 8'h0, 8'h0, 8'h62, 1'b0, 4'h8, 1'b1, 4'h8, 1'b1, 32'h62);
    step("t5.arb0", 4'h1, 4'h1, 8'h70, 8'h0, 8'h0, 8'h0, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 32'h0);
    step("t5.r0",   4'h1, 4'h1, 8'h70, 8'h0, 8'h0, 8'h0, 1'b0, 4'h1, 1'b1, 4'h1, 1'b1, 32'h70);
    step("t5.idle", 4'h0, 4'h0, 8'h0, 8'h0, 8'h0, 8'h0, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 32'h0);

    // Reset during beat 2 of a 5-beat packet from req 2
    step("t6.arb",  4'h4, 4'h0, 8'h0, 8'h0, 8'h80, 8'h0, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 32'h0);
    step("t6.b0",   4'h4, 4'h0, 8'h0, 8'h0, 8'h80, 8'h0, 1'b0, 4'h4, 1'b1, 4'h4, 1'b1, 32'h80);
    rst = 1'b1;
    step("t6.b1",   4'h4, 4'h0, 8'h0, 8'h0, 8'h81, 8'h0, 1'b0, 4'h4, 1'b1, 4'h4, 1'b1, 32'h81);
    chk("t6.rr_ptr", 32'(dut.rr_ptr_reg), 32'd0);
    step("t6.rst",  4'h4, 4'h0, 8'h0, 8'h0, 8'h82, 8'h0, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 32'h0);
    rst = 1'b0;
    // From rr_ptr 0, requester 0 wins over 3
    step("t6.arb2", 4'h9, 4'h0, 8'h90, 8'h0, 8'h0, 8'h91, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 32'h0);
    step("t6.r0",   4'h9, 4'h1, 8'h90, 8'h0, 8'h0, 8'h91, 1'b0, 4'h1, 1'b1, 4'h1, 1'b1, 32'h90);
    step("t6.idle", 4'h0, 4'h0, 8'h0, 8'h0, 8'h0, 8'h0, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
